// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : imem_loader                                                |
// | Purpose : Assembles a little-endian byte stream into 32-bit words,   |
// |           writes them to instruction memory, and holds the core in   |
// |           reset until a load completes. Define                       |
// |           IMEM_LOADER_CHECKSUM_EN for a trailing mod-256 checksum.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  checksum_err
);

  localparam logic [ADDR_WIDTH:0]   C_MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_ONE_W     = 1;
  localparam logic [ADDR_WIDTH-1:0] C_ONE_A     = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd3,
`endif
    S_FINISH = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_WIDTH:0] r_words_left;
  logic [1:0]          r_byte_cnt;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_checksum_err;
  assign checksum_err = r_checksum_err;
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      in_ready     <= 1'b0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum          <= '0;
      r_checksum_err <= 1'b0;
`endif
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_words_left <= (num_words > C_MAX_WORDS) ? C_MAX_WORDS : num_words;
            waddr        <= '0;
            r_byte_cnt   <= '0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
            r_checksum_err <= 1'b0;
`endif
            // An empty load finishes immediately; nothing can be wrong with it.
            if (num_words == '0) begin
              r_state <= S_FINISH;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              r_state  <= S_RECV;
              in_ready <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (in_valid && in_ready) begin
            case (r_byte_cnt)
              2'd0:    wdata[7:0]   <= in_byte;
              2'd1:    wdata[15:8]  <= in_byte;
              2'd2:    wdata[23:16] <= in_byte;
              default: wdata[31:24] <= in_byte;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + in_byte;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_state  <= S_WRITE;
              in_ready <= 1'b0;
              we       <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          waddr        <= waddr + C_ONE_A;
          r_words_left <= r_words_left - C_ONE_W;
          if (r_words_left == C_ONE_W) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state  <= S_CHECK;
            in_ready <= 1'b1;
`else
            r_state <= S_FINISH;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
`endif
          end else begin
            r_state  <= S_RECV;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid && in_ready) begin
            r_checksum_err <= (in_byte != r_sum);
            cpu_rst        <= (in_byte != r_sum);
            in_ready       <= 1'b0;
            done           <= 1'b1;
            r_state        <= S_FINISH;
          end
        end
`endif

        S_FINISH: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_imem_loader                                             |
// | Purpose : Directed self-checking bench for imem_loader with a write  |
// |           scoreboard; honours IMEM_LOADER_CHECKSUM_EN if defined.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int C_CK = 1;
`else
  localparam int C_CK = 0;
`endif

  logic                  clk       = 1'b0;
  logic                  rst       = 1'b0;
  logic                  start     = 1'b0;
  logic [ADDR_WIDTH:0]   num_words = '0;
  logic [7:0]            in_byte   = '0;
  logic                  in_valid  = 1'b0;
  logic                  in_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  checksum_err;

  imem_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_words    (num_words),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .checksum_err (checksum_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_w;
  logic [7:0] byte_q[$];
  int total = 0;
  int bad   = 0;
  int n_we, n_done, n_ready, n_rst_low;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (we === 1'b1) begin
        n_we++;
        chk("we_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("waddr", 64'(waddr), 64'(exp_w.a));
          chk("wdata", 64'(wdata), 64'(exp_w.d));
        end
      end
      if (done === 1'b1) n_done++;
      if (in_ready === 1'b1) n_ready++;
      if (busy === 1'b1 && done !== 1'b1 && cpu_rst !== 1'b1) n_rst_low++;
    end
  end

  task automatic push_word(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
    byte_q.push_back(d[7:0]);
    byte_q.push_back(d[15:8]);
    byte_q.push_back(d[23:16]);
    byte_q.push_back(d[31:24]);
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (byte_q[i]) s = s + byte_q[i];
    byte_q.push_back(s);
`endif
  endtask

  task automatic clear_stats();
    @(posedge clk);
    #1;
    n_we      = 0;
    n_done    = 0;
    n_ready   = 0;
    n_rst_low = 0;
  endtask

  // Cycle 0 is the start cycle; done_at is the cycle index where done is seen, -1 if the budget ran out.
  task automatic run_load(input int nw, input bit toggle, input int budget, input int poke_at,
                          output int done_at, output int used);
    int idx;
    int cyc;
    idx     = 0;
    done_at = -1;
    @(negedge clk);
    start     = 1'b1;
    num_words = nw[ADDR_WIDTH:0];
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc <= budget) begin
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
      start = (cyc == poke_at);
      if (cyc == poke_at) num_words = 9'd5;
      in_valid = toggle ? cyc[0] : 1'b1;
      in_byte  = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
      if (in_valid && in_ready === 1'b1) idx++;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    used     = idx;
  endtask

  initial begin
    int d;
    int u;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cksum_err", 64'(checksum_err), 64'd0);
    rst = 1'b1;

    // Two-word load, stray start mid-load must be ignored
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'h00100513);
    push_word(8'd1, 32'hFFF00593);
    add_csum();
    run_load(2, 1'b0, 40, 3, d, u);
    chk("t1_done_cycle", 64'(d), 64'(11 + C_CK));
    chk("t1_bytes_used", 64'(u), 64'(8 + C_CK));
    chk("t1_cpu_rst_at_done", 64'(cpu_rst), 64'd0);
    chk("t1_cpu_rst_held", 64'(n_rst_low), 64'd0);
    repeat (3) @(negedge clk);
    chk("t1_writes", 64'(n_we), 64'd2);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    chk("t1_done_pulses", 64'(n_done), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Zero-word load
    clear_stats();
    byte_q.delete();
    run_load(0, 1'b0, 10, 0, d, u);
    chk("t2_done_cycle", 64'(d), 64'd1);
    repeat (3) @(negedge clk);
    chk("t2_writes", 64'(n_we), 64'd0);
    chk("t2_ready_cycles", 64'(n_ready), 64'd0);
    chk("t2_done_pulses", 64'(n_done), 64'd1);

    // in_valid toggling every other cycle
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'hDEADBEEF);
    add_csum();
    run_load(1, 1'b1, 60, 0, d, u);
    chk("t3_done_cycle", 64'(d), 64'(9 + C_CK));
    chk("t3_bytes_used", 64'(u), 64'(4 + C_CK));
    repeat (2) @(negedge clk);
    chk("t3_writes", 64'(n_we), 64'd1);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-load after 2 bytes of word 1, then a fresh 1-word load
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'h11223344);
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hBB);
    run_load(3, 1'b0, 7, 0, d, u);
    chk("t4_bytes_before_rst", 64'(u), 64'd6);
    rst = 1'b0;
    #1;
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_wdata", 64'(wdata), 64'd0);
    chk("t4_rst_waddr", 64'(waddr), 64'd0);
    chk("t4_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t4_first_writes", 64'(n_we), 64'd1);
    chk("t4_sb_empty_pre", 64'(sb.size()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_stats();
    chk("t4_cpu_rst_idle", 64'(cpu_rst), 64'd1);
    byte_q.delete();
    push_word(8'd0, 32'h00000013);
    add_csum();
    run_load(1, 1'b0, 30, 0, d, u);
    chk("t4_done_cycle", 64'(d), 64'(6 + C_CK));
    chk("t4_cpu_rst_at_done", 64'(cpu_rst), 64'd0);
    chk("t4_cpu_rst_held", 64'(n_rst_low), 64'd0);
    repeat (2) @(negedge clk);
    chk("t4_writes", 64'(n_we), 64'd1);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum, then bad checksum
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'h04030201);
    byte_q.push_back(8'h0A);
    run_load(1, 1'b0, 30, 0, d, u);
    chk("t5_good_done_cycle", 64'(d), 64'd7);
    chk("t5_good_err", 64'(checksum_err), 64'd0);
    chk("t5_good_cpu_rst", 64'(cpu_rst), 64'd0);
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'h04030201);
    byte_q.push_back(8'h0B);
    run_load(1, 1'b0, 30, 0, d, u);
    chk("t5_bad_done_cycle", 64'(d), 64'd7);
    chk("t5_bad_err", 64'(checksum_err), 64'd1);
    chk("t5_bad_cpu_rst", 64'(cpu_rst), 64'd1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", 64'(checksum_err), 64'd1);
    chk("t5_cpu_rst_sticky", 64'(cpu_rst), 64'd1);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
`else
    // No trailing checksum byte may be consumed
    clear_stats();
    byte_q.delete();
    push_word(8'd0, 32'h04030201);
    byte_q.push_back(8'h0B);
    run_load(1, 1'b0, 30, 0, d, u);
    chk("t5_done_cycle", 64'(d), 64'd6);
    chk("t5_bytes_used", 64'(u), 64'd4);
    chk("t5_err_tied", 64'(checksum_err), 64'd0);
    chk("t5_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("t5_ready_cycles", 64'(n_ready), 64'd4);
    repeat (2) @(negedge clk);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
`endif

    // Oversized count clamps to 256 words, waddr 0x00..0xFF
    clear_stats();
    byte_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      push_word(b, {b, ~b, b ^ 8'hA5, 8'h3C});
    end
    add_csum();
    run_load(300, 1'b0, 1400, 0, d, u);
    chk("t6_done_cycle", 64'(d), 64'(1281 + C_CK));
    chk("t6_err", 64'(checksum_err), 64'd0);
    chk("t6_cpu_rst", 64'(cpu_rst), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_writes", 64'(n_we), 64'd256);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    chk("t6_done_pulses", 64'(n_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
